// File: rtl/sm_gpio_debouncer.sv
// Conditions raw board GPIO pins: a 2-flop synchronizer, then a per-bit debounce sampled on a shared prescaler strobe.
// Also emits registered one-cycle rise, fall and changed event pulses.
module sm_gpio_debouncer #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 1000,
    parameter int STABLE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = $clog2(STABLE + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PERIOD - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(STABLE - 1);

    logic [WIDTH-1:0] sync1_reg, sync2_reg;
    logic [PW-1:0]    pre_reg, pre_next;
    logic             strobe;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] gpio_reg, gpio_next;
    logic [WIDTH-1:0] rise_reg, rise_next;
    logic [WIDTH-1:0] fall_reg, fall_next;
    logic             changed_reg, changed_next;

    // The synchronizer keeps running while en is low, so s2 is already settled when sampling resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign strobe = en && (pre_reg == PRE_LAST);

    always_comb begin
        pre_next = pre_reg;
        if (!en) begin
            pre_next = '0;
        end else if (pre_reg == PRE_LAST) begin
            pre_next = '0;
        end else begin
            pre_next = pre_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [DW-1:0] dcnt_reg, dcnt_next;
            logic          differ;

            assign differ     = sync2_reg[gi] ^ gpio_reg[gi];
            assign accept[gi] = strobe && differ && (dcnt_reg == DCNT_LAST);

            // Any matching sample restarts the run, which is what rejects short glitches.
            always_comb begin
                dcnt_next = dcnt_reg;
                if (strobe) begin
                    if (!differ || accept[gi]) begin
                        dcnt_next = '0;
                    end else begin
                        dcnt_next = dcnt_reg + DW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dcnt_reg <= '0;
                end else begin
                    dcnt_reg <= dcnt_next;
                end
            end
        end
    endgenerate

    assign gpio_next    = gpio_reg ^ accept;
    assign rise_next    = accept & sync2_reg;
    assign fall_next    = accept & ~sync2_reg;
    assign changed_next = |accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_reg    <= '0;
            rise_reg    <= '0;
            fall_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            gpio_reg    <= gpio_next;
            rise_reg    <= rise_next;
            fall_reg    <= fall_next;
            changed_reg <= changed_next;
        end
    end

    assign gpio_out = gpio_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign changed  = changed_reg;

endmodule

// File: tb/tb_sm_gpio_debouncer.sv
// Bench for sm_gpio_debouncer: directed scenarios plus random stimulus.
// Two instances (PERIOD=1/STABLE=3 and PERIOD=4/STABLE=2) are checked against a run-length reference model.
module tb_sm_gpio_debouncer;
    localparam int PER_A = 1, ST_A = 3, PER_B = 4, ST_B = 2;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, en_a, en_b;
    logic [15:0] raw_a, raw_b;
    logic [15:0] gpio_a, rise_a, fall_a, gpio_b, rise_b, fall_b;
    logic        changed_a, changed_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sm_gpio_debouncer #(.WIDTH(16), .PERIOD(PER_A), .STABLE(ST_A)) dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .raw_in(raw_a),
        .gpio_out(gpio_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
    );

    sm_gpio_debouncer #(.WIDTH(16), .PERIOD(PER_B), .STABLE(ST_B)) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .raw_in(raw_b),
        .gpio_out(gpio_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what the pins looked like two edges ago, enabled cycles elapsed,
    // and per-bit run length of consecutive differing samples.
    logic [15:0] m_p1 [2];
    logic [15:0] m_p2 [2];
    logic [15:0] m_gpio [2];
    logic [15:0] m_rise [2];
    logic [15:0] m_fall [2];
    logic        m_chg [2];
    int          m_encyc [2];
    int          m_run [2][16];

    function automatic int per_of(input int k);
        return (k == 0) ? PER_A : PER_B;
    endfunction

    function automatic int st_of(input int k);
        return (k == 0) ? ST_A : ST_B;
    endfunction

    task automatic model_edge(input int k, input logic rst, input logic en, input logic [15:0] raw);
        bit strobe;
        if (!rst) begin
            m_p1[k] = '0; m_p2[k] = '0; m_gpio[k] = '0;
            m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0; m_encyc[k] = 0;
            for (int b = 0; b < 16; b++) m_run[k][b] = 0;
            return;
        end
        strobe = en && ((m_encyc[k] % per_of(k)) == per_of(k) - 1);
        m_rise[k] = '0;
        m_fall[k] = '0;
        if (strobe) begin
            for (int b = 0; b < 16; b++) begin
                if (m_p2[k][b] != m_gpio[k][b]) begin
                    m_run[k][b]++;
                    if (m_run[k][b] == st_of(k)) begin
                        m_gpio[k][b] = m_p2[k][b];
                        if (m_p2[k][b]) m_rise[k][b] = 1'b1;
                        else m_fall[k][b] = 1'b1;
                        m_run[k][b] = 0;
                    end
                end else begin
                    m_run[k][b] = 0;
                end
            end
        end
        m_chg[k]   = |(m_rise[k] | m_fall[k]);
        m_encyc[k] = en ? m_encyc[k] + 1 : 0;
        m_p2[k]    = m_p1[k];
        m_p1[k]    = raw;
    endtask

    always @(posedge clk) begin
        model_edge(0, rst_a, en_a, raw_a);
        model_edge(1, rst_b, en_b, raw_b);
    end

    // Continuous comparison on the falling edge; asserted reset forces all outputs to 0.
    always @(negedge clk) begin
        check_eq("a_gpio", gpio_a, rst_a ? m_gpio[0] : 16'h0);
        check_eq("a_rise", rise_a, rst_a ? m_rise[0] : 16'h0);
        check_eq("a_fall", fall_a, rst_a ? m_fall[0] : 16'h0);
        check_eq("a_changed", changed_a, rst_a ? m_chg[0] : 1'b0);
        check_eq("b_gpio", gpio_b, rst_b ? m_gpio[1] : 16'h0);
        check_eq("b_rise", rise_b, rst_b ? m_rise[1] : 16'h0);
        check_eq("b_fall", fall_b, rst_b ? m_fall[1] : 16'h0);
        check_eq("b_changed", changed_b, rst_b ? m_chg[1] : 1'b0);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int rst_hold;
        logic [15:0] mask;

        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        raw_a = 16'hFFFF; raw_b = 16'h0000;

        // Reset with all pins high, then the 2+STABLE latency after release.
        tick(3);
        check_eq("t1_rst_gpio", gpio_a, 16'h0);
        check_eq("t1_rst_rise", rise_a, 16'h0);
        check_eq("t1_rst_changed", changed_a, 1'b0);
        rst_a = 1'b1; rst_b = 1'b1;
        tick(4);
        check_eq("t1_edge4_gpio", gpio_a, 16'h0);
        tick(1);
        check_eq("t1_edge5_gpio", gpio_a, 16'hFFFF);
        check_eq("t1_edge5_rise", rise_a, 16'hFFFF);
        check_eq("t1_edge5_changed", changed_a, 1'b1);
        tick(1);
        check_eq("t1_edge6_rise", rise_a, 16'h0);
        check_eq("t1_edge6_changed", changed_a, 1'b0);

        // Clean steps.
        raw_a = 16'h0000;
        tick(10);
        check_eq("t2_settle_gpio", gpio_a, 16'h0);
        raw_a = 16'h0052;
        tick(4);
        check_eq("t2_edge4_gpio", gpio_a, 16'h0);
        tick(1);
        check_eq("t2_edge5_gpio", gpio_a, 16'h0052);
        check_eq("t2_edge5_rise", rise_a, 16'h0052);
        check_eq("t2_edge5_fall", fall_a, 16'h0);
        tick(1);
        check_eq("t2_edge6_rise", rise_a, 16'h0);
        raw_a = 16'h0050;
        tick(5);
        check_eq("t2_fall_gpio", gpio_a, 16'h0050);
        check_eq("t2_fall_fall", fall_a, 16'h0002);

        // Two-cycle glitch is rejected, three-cycle pulse is accepted.
        tick(3);
        raw_a = 16'h0051;
        tick(2);
        raw_a = 16'h0050;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_eq("t3_glitch_gpio", gpio_a, 16'h0050);
            check_eq("t3_glitch_changed", changed_a, 1'b0);
        end
        raw_a = 16'h0051;
        tick(3);
        raw_a = 16'h0050;
        tick(1);
        check_eq("t3_edge4_gpio", gpio_a, 16'h0050);
        tick(1);
        check_eq("t3_edge5_rise", rise_a, 16'h0001);
        tick(2);
        check_eq("t3_edge7_gpio", gpio_a, 16'h0051);
        check_eq("t3_edge7_fall", fall_a, 16'h0);
        tick(1);
        check_eq("t3_edge8_fall", fall_a, 16'h0001);
        check_eq("t3_edge8_gpio", gpio_a, 16'h0050);

        // Prescaled instance: latency window for a step on bit 5.
        raw_b = 16'h0020;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick(1);
            if (gpio_b[5]) n = i;
        end
        check_eq("t4_latency_in_window", (n >= 7 && n <= 10), 1'b1);

        // Enable freeze part-way through a count.
        tick(2);
        en_b = 1'b0;
        raw_b = 16'h0000;
        tick(4);
        en_b = 1'b1;
        tick(4);
        en_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("t5_hold_gpio", gpio_b, 16'h0020);
            check_eq("t5_hold_changed", changed_b, 1'b0);
        end
        en_b = 1'b1;
        tick(3);
        check_eq("t5_edge3_gpio", gpio_b, 16'h0020);
        tick(1);
        check_eq("t5_edge4_gpio", gpio_b, 16'h0000);
        check_eq("t5_edge4_fall", fall_b, 16'h0020);
        check_eq("t5_edge4_changed", changed_b, 1'b1);

        // Asynchronous reset mid-count.
        raw_a = 16'h00FF;
        tick(10);
        check_eq("t6_pre_gpio", gpio_a, 16'h00FF);
        raw_a = 16'h0000;
        tick(4);
        #2;
        rst_a = 1'b0;
        #1;
        check_eq("t6_async_gpio", gpio_a, 16'h0);
        check_eq("t6_async_rise", rise_a, 16'h0);
        check_eq("t6_async_fall", fall_a, 16'h0);
        check_eq("t6_async_changed", changed_a, 1'b0);
        raw_a = 16'h00FF;
        tick(2);
        rst_a = 1'b1;
        tick(4);
        check_eq("t6_edge4_gpio", gpio_a, 16'h0);
        tick(1);
        check_eq("t6_edge5_gpio", gpio_a, 16'h00FF);
        check_eq("t6_edge5_rise", rise_a, 16'h00FF);

        // Random phase checked by the model every cycle.
        rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ($urandom_range(5, 0) == 0) begin
                mask = 16'(1) << $urandom_range(15, 0);
                if ($urandom_range(2, 0) == 0) mask = mask | 16'($urandom);
                raw_a = raw_a ^ mask;
            end
            if ($urandom_range(9, 0) == 0) begin
                mask = 16'(1) << $urandom_range(15, 0);
                raw_b = raw_b ^ mask;
            end
            if ($urandom_range(39, 0) == 0) en_a = ~en_a;
            if ($urandom_range(39, 0) == 0) en_b = ~en_b;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) begin
                    rst_a = 1'b1;
                    rst_b = 1'b1;
                end
            end else if ($urandom_range(499, 0) == 0) begin
                rst_hold = 2;
                if ($urandom_range(1, 0) == 0) rst_a = 1'b0;
                else rst_b = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
